// File: rtl/data_types_pkg.sv
// Shared micro-op types and the issue-queue entry layout used by the scheduler.
package data_types;

  localparam int ISSUE_PORTS  = 2;
  localparam int PORT_ALU     = 0;
  localparam int PORT_SH      = 1;
  localparam int IQ_TAG_MAX_W = 16;
  localparam int RANK_W       = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_LUI  = 4'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    SH_SLL  = 3'd0,
    SH_SRL  = 3'd1,
    SH_SRA  = 3'd2,
    SH_SLLI = 3'd3,
    SH_SRLI = 3'd4,
    SH_SRAI = 3'd5
  } shift_op_t;

  typedef enum logic [2:0] {
    GRP_ALU    = 3'd0,
    GRP_SHIFT  = 3'd1,
    GRP_MUL    = 3'd2,
    GRP_LSU    = 3'd3,
    GRP_BRANCH = 3'd4
  } functional_group_t;

  // Tags are held at the widest supported width; the scheduler zero-extends TAG_W tags.
  typedef struct packed {
    logic                    valid;
    functional_group_t       group;
    alu_op_t                 alu_op;
    shift_op_t               shift_op;
    logic [IQ_TAG_MAX_W-1:0] src1_tag;
    logic                    src1_rdy;
    logic [IQ_TAG_MAX_W-1:0] src2_tag;
    logic                    src2_rdy;
    logic [IQ_TAG_MAX_W-1:0] dst_tag;
    logic [RANK_W-1:0]       rank;
  } iq_entry_t;

endpackage

// File: rtl/issue_sched_age_select.sv
// Oldest-first picker: grants the eligible entry with the lowest rank (index breaks ties).
module age_select
  import data_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]             elig,
  input  logic [DEPTH-1:0][RANK_W-1:0] rank,
  output logic [DEPTH-1:0]             grant,
  output logic                         valid
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] &&
            ((rank[j] < rank[i]) || ((rank[j] == rank[i]) && (j < i))))
          grant[i] = 1'b0;
      end
    end
  end

  assign valid = |elig;

endmodule

// File: rtl/issue_sched.sv
// Age-ordered issue queue feeding ALU and shifter ports with result-bus wakeup.
// Optional ISSUE_SCHED_WB_BYPASS_EN lets a same-cycle broadcast make an entry eligible.
module issue_sched
  import data_types::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  functional_group_t          enq_group_i,
  input  alu_op_t                    enq_alu_op_i,
  input  shift_op_t                  enq_shift_op_i,
  input  logic [TAG_W-1:0]           enq_src1_tag_i,
  input  logic [TAG_W-1:0]           enq_src2_tag_i,
  input  logic                       enq_src1_rdy_i,
  input  logic                       enq_src2_rdy_i,
  input  logic [TAG_W-1:0]           enq_dst_tag_i,
  input  logic                       wb_valid_i,
  input  logic [TAG_W-1:0]           wb_tag_i,
  output logic                       alu_valid_o,
  input  logic                       alu_ready_i,
  output alu_op_t                    alu_op_o,
  output logic [TAG_W-1:0]           alu_src1_tag_o,
  output logic [TAG_W-1:0]           alu_src2_tag_o,
  output logic [TAG_W-1:0]           alu_dst_tag_o,
  output logic                       sh_valid_o,
  input  logic                       sh_ready_i,
  output shift_op_t                  sh_op_o,
  output logic [TAG_W-1:0]           sh_src1_tag_o,
  output logic [TAG_W-1:0]           sh_src2_tag_o,
  output logic [TAG_W-1:0]           sh_dst_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  iq_entry_t                            q   [DEPTH];
  iq_entry_t                            q_n [DEPTH];
  logic [DEPTH-1:0][RANK_W-1:0]         rank_vec;
  logic [ISSUE_PORTS-1:0][DEPTH-1:0]    elig;
  logic [ISSUE_PORTS-1:0][DEPTH-1:0]    grant;
  logic [ISSUE_PORTS-1:0]               port_vld;
  logic [ISSUE_PORTS-1:0]               port_rdy;
  logic [ISSUE_PORTS-1:0]               fire;
  logic [DEPTH-1:0]                     issued;
  logic [CNT_W-1:0]                     count;
  logic [CNT_W-1:0]                     n_issued;
  logic                                 enq_fire;
  logic [IQ_TAG_MAX_W-1:0]              wb_tag_x;
  logic [IQ_TAG_MAX_W-1:0]              enq_src1_x;
  logic [IQ_TAG_MAX_W-1:0]              enq_src2_x;

  assign wb_tag_x   = IQ_TAG_MAX_W'(wb_tag_i);
  assign enq_src1_x = IQ_TAG_MAX_W'(enq_src1_tag_i);
  assign enq_src2_x = IQ_TAG_MAX_W'(enq_src2_tag_i);

  always_comb begin
    logic r1;
    logic r2;
    r1       = 1'b0;
    r2       = 1'b0;
    elig     = '0;
    rank_vec = '0;
    count    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r1 = q[i].src1_rdy;
      r2 = q[i].src2_rdy;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
      r1 = r1 | (wb_valid_i && (q[i].src1_tag == wb_tag_x));
      r2 = r2 | (wb_valid_i && (q[i].src2_tag == wb_tag_x));
`endif
      elig[PORT_ALU][i] = q[i].valid && r1 && r2 && (q[i].group == GRP_ALU);
      elig[PORT_SH][i]  = q[i].valid && r1 && r2 && (q[i].group == GRP_SHIFT);
      rank_vec[i]       = q[i].rank;
      count             = count + CNT_W'(q[i].valid);
    end
  end

  for (genvar p = 0; p < ISSUE_PORTS; p++) begin : g_sel
    age_select #(.DEPTH(DEPTH)) u_sel (
      .elig  (elig[p]),
      .rank  (rank_vec),
      .grant (grant[p]),
      .valid (port_vld[p])
    );
  end

  assign port_rdy[PORT_ALU] = alu_ready_i;
  assign port_rdy[PORT_SH]  = sh_ready_i;
  assign fire        = port_vld & port_rdy & {ISSUE_PORTS{~flush_i}};
  assign alu_valid_o = port_vld[PORT_ALU];
  assign sh_valid_o  = port_vld[PORT_SH];
  assign count_o     = count;
  assign enq_ready_o = (count < DEPTH_C) &&
                       ((enq_group_i == GRP_ALU) || (enq_group_i == GRP_SHIFT));
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;

  always_comb begin
    issued   = '0;
    n_issued = '0;
    for (int p = 0; p < ISSUE_PORTS; p++)
      if (fire[p]) issued = issued | grant[p];
    for (int i = 0; i < DEPTH; i++)
      n_issued = n_issued + CNT_W'(issued[i]);
  end

  // Payload is a one-hot mux of the granted entry; zero when nothing is granted.
  always_comb begin
    alu_op_o       = alu_op_t'(4'd0);
    alu_src1_tag_o = '0;
    alu_src2_tag_o = '0;
    alu_dst_tag_o  = '0;
    sh_op_o        = shift_op_t'(3'd0);
    sh_src1_tag_o  = '0;
    sh_src2_tag_o  = '0;
    sh_dst_tag_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[PORT_ALU][i]) begin
        alu_op_o       = q[i].alu_op;
        alu_src1_tag_o = q[i].src1_tag[TAG_W-1:0];
        alu_src2_tag_o = q[i].src2_tag[TAG_W-1:0];
        alu_dst_tag_o  = q[i].dst_tag[TAG_W-1:0];
      end
      if (grant[PORT_SH][i]) begin
        sh_op_o       = q[i].shift_op;
        sh_src1_tag_o = q[i].src1_tag[TAG_W-1:0];
        sh_src2_tag_o = q[i].src2_tag[TAG_W-1:0];
        sh_dst_tag_o  = q[i].dst_tag[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    logic [RANK_W-1:0] dec;
    logic              taken;
    dec   = '0;
    taken = 1'b0;
    q_n   = q;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid) begin
        if (issued[i]) begin
          q_n[i].valid = 1'b0;
          q_n[i].rank  = '0;
        end else begin
          // Survivors move up by the number of issued entries older than them.
          dec = '0;
          for (int j = 0; j < DEPTH; j++)
            if (issued[j] && (q[j].rank < q[i].rank)) dec = dec + RANK_W'(1);
          q_n[i].rank = q[i].rank - dec;
          if (wb_valid_i && (q[i].src1_tag == wb_tag_x)) q_n[i].src1_rdy = 1'b1;
          if (wb_valid_i && (q[i].src2_tag == wb_tag_x)) q_n[i].src2_rdy = 1'b1;
        end
      end else if (!taken) begin
        taken = 1'b1;
        if (enq_fire) begin
          q_n[i].valid    = 1'b1;
          q_n[i].group    = enq_group_i;
          q_n[i].alu_op   = enq_alu_op_i;
          q_n[i].shift_op = enq_shift_op_i;
          q_n[i].src1_tag = enq_src1_x;
          q_n[i].src1_rdy = enq_src1_rdy_i || (wb_valid_i && (enq_src1_x == wb_tag_x));
          q_n[i].src2_tag = enq_src2_x;
          q_n[i].src2_rdy = enq_src2_rdy_i || (wb_valid_i && (enq_src2_x == wb_tag_x));
          q_n[i].dst_tag  = IQ_TAG_MAX_W'(enq_dst_tag_i);
          q_n[i].rank     = RANK_W'(count - n_issued);
        end
      end
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_n[i].valid = 1'b0;
        q_n[i].rank  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
    end
  end

endmodule

// File: doc/issue_sched.md
# issue_sched

Issue scheduler between `instruc_decode` and the execute stage. Holds up to `DEPTH` decoded micro-ops, tracks source-operand readiness by snooping the result broadcast bus, and issues the oldest ready op to one of two functional units (ALU, shifter) through independent valid/ready ports. It is the single arbiter deciding which in-flight instruction may use each execution resource in a given cycle.

## Interface
- `DEPTH`, 4: queue entries (2–16).
- `TAG_W`, 6: physical register tag width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: discard all entries.
- `enq_valid_i` in 1: decoded op offered.
- `enq_ready_o` out 1: queue can accept.
- `enq_group_i` in `functional_group_t`: target unit class.
- `enq_alu_op_i` in `alu_op_t`; `enq_shift_op_i` in `shift_op_t`: op payload.
- `enq_src1_tag_i`, `enq_src2_tag_i` in TAG_W; `enq_src1_rdy_i`, `enq_src2_rdy_i` in 1: operand tags/readiness at decode.
- `enq_dst_tag_i` in TAG_W: destination tag.
- `wb_valid_i` in 1; `wb_tag_i` in TAG_W: result broadcast (wakeup).
- `alu_valid_o` out 1; `alu_ready_i` in 1; `alu_op_o` out `alu_op_t`; `alu_src1_tag_o`, `alu_src2_tag_o`, `alu_dst_tag_o` out TAG_W.
- `sh_valid_o` out 1; `sh_ready_i` in 1; `sh_op_o` out `shift_op_t`; `sh_src1_tag_o`, `sh_src2_tag_o`, `sh_dst_tag_o` out TAG_W.
- `count_o` out $clog2(DEPTH+1): occupied entries.

## Operation
- Entry state: valid, group, op, src tags + ready bits, dst tag, rank (0 = oldest).
- Enqueue fires on `enq_valid_i && enq_ready_o`; writes the lowest-index free entry; rank = count of entries surviving this cycle.
- `enq_ready_o = (count_o < DEPTH)`; does not account for same-cycle issue frees.
- Wakeup: any valid entry source with tag == `wb_tag_i` while `wb_valid_i` sets its ready bit. An op enqueued with a matching tag in the same cycle captures ready (always, regardless of macro).
- Eligible: valid, both sources ready, group matches port (ALU group → ALU port, SHIFT group → shifter port). Other groups are not accepted: `enq_ready_o` is low for them.
- Select per port: lowest-rank eligible entry; port valid = any eligible.
- Issue fires on `*_valid_o && *_ready_i`; entry freed at that edge; every surviving entry's rank decrements by the number of issued entries older than it (0, 1 or 2).
- Selection is recomputed every cycle; payload is stable only while the selected entry is unchanged. Consumers sample on fire only.
- `flush_i`: all entries invalid at next edge; beats same-cycle enqueue and issue (neither takes effect); `*_valid_o` still reflect pre-flush state that cycle.

## Timing
- Reset: all entries invalid, ranks 0; `count_o=0`, `enq_ready_o=1`, `alu_valid_o=sh_valid_o=0`, all payload outputs 0.
- Enqueue-to-issue: minimum 1 cycle (enqueue edge N, `*_valid_o` high in cycle N+1 when sources ready).
- Wakeup-to-issue: see Configuration.
- Full + issue + enqueue same cycle: enqueue blocked (ready low); issue frees entry; `enq_ready_o` high next cycle.
- Simultaneous enqueue and issue of different entries: `count_o` unchanged.
- Reset mid-operation: all state cleared immediately, no partial issue.

## Configuration
- `ISSUE_SCHED_WB_BYPASS_EN` defined: a source matching the current-cycle `wb_tag_i` counts ready for selection in that cycle (wakeup-to-issue 0 cycles; combinational path `wb_*` → `*_valid_o`).
- Undefined: selection uses registered ready bits only; woken entry becomes eligible the cycle after the broadcast (1-cycle wakeup-to-issue, all outputs from registers except ready-gated handshakes).

## Structure
- `data_types` package: `iq_entry_t` struct (fields above) and `ISSUE_PORTS = 2` constant; reuse existing `alu_op_t`, `shift_op_t`, `functional_group_t`.
- Sub-module `age_select`: DEPTH-wide eligible vector + ranks → one-hot grant and valid; instantiated once per port.

## Test plan
- Reset, enqueue ALU ADD with both sources ready → `alu_valid_o`=1 next cycle, `alu_op_o`=ADD, fire with `alu_ready_i`=1 → `count_o` 1→0.
- Enqueue XOR (src1 tag 5 not ready), then ADD (ready) → ADD issues first; broadcast tag 5 → XOR issues 1 cycle later (0 with macro).
- Enqueue 4 ALU ops all ready, `alu_ready_i`=0 → `enq_ready_o`=0, `count_o`=4; raise ready → issue in enqueue order, one per cycle.
- SLLI and ADD ready simultaneously, both ports ready → both issue same cycle, `count_o` drops by 2, remaining ranks decrement by 2.
- Enqueue with src tag equal to same-cycle `wb_tag_i` → entry issues next cycle without further broadcast.
- 3 entries pending, assert `flush_i` with simultaneous enqueue → `count_o`=0 next cycle, no op issued afterwards.
